// File: rtl/addr_gen_hc_seq_if.sv
// Handshake bundle between the H/C address sequencer and its memory-read consumer.
// The generator side uses the master modport; the consumer side uses slave.
interface addr_gen_hc_seq_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  i_start;
  logic                  i_mode;
  logic                  i_ready;
  logic [ADDR_WIDTH-1:0] o_addr_h;
  logic [ADDR_WIDTH-1:0] o_addr_c;
  logic                  o_valid;
  logic                  o_last;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    input  i_start, i_mode, i_ready,
    output o_addr_h, o_addr_c, o_valid, o_last, o_busy, o_done
  );

  modport slave (
    output i_start, i_mode, i_ready,
    input  o_addr_h, o_addr_c, o_valid, o_last, o_busy, o_done
  );
endinterface

// File: rtl/addr_gen_hc_seq.sv
// H/C address sequencer: for each timestep slot and each cell, bursts the H row
// addresses of the slot while holding the C address of that cell, with idle gaps.
module addr_gen_hc_seq #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 8,
  parameter int NUM_CELL   = 8,
  parameter int DELAY      = 3,
  parameter int BASE_H     = 0,
  parameter int BASE_C     = 0
) (
  input logic               clk,
  input logic               rst,
  addr_gen_hc_seq_if.master bus
);

  localparam int SW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
  localparam int CW = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
  localparam int GW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(TIMESTEP - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(NUM_CELL - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((DELAY > 0) ? DELAY - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

  state_t                r_state;
  logic                  r_mode;
  logic [SW-1:0]         r_slot;
  logic [CW-1:0]         r_cell;
  logic [CW-1:0]         r_beat;
  logic [GW-1:0]         r_gap;
  logic [ADDR_WIDTH-1:0] r_addr_h;
  logic [ADDR_WIDTH-1:0] r_addr_c;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_final;
  logic                  w_beat_last;
  logic [CW-1:0]         w_ncell;
  logic [SW-1:0]         w_nslot;
  logic [ADDR_WIDTH-1:0] w_h_next;
  logic [ADDR_WIDTH-1:0] w_nb_h;
  logic [ADDR_WIDTH-1:0] w_nb_c;
  logic [ADDR_WIDTH-1:0] w_start_h;
  logic [ADDR_WIDTH-1:0] w_start_c;

  // Addresses wrap naturally by truncation to ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] addr_of(input int base, input int slot, input int idx);
    logic [31:0] sum;
    sum = 32'(base + slot * NUM_CELL + idx);
    return sum[ADDR_WIDTH-1:0];
  endfunction

  // r_slot counts iterations; backward runs map iteration 0 to the highest slot.
  function automatic int phys_slot(input logic mode, input int iter);
    return mode ? (TIMESTEP - 1 - iter) : iter;
  endfunction

  always_comb begin
    w_beat_last = (r_beat == CELL_LAST);
    w_final     = (r_cell == CELL_LAST) && (r_slot == SLOT_LAST);
    w_ncell     = (r_cell == CELL_LAST) ? '0 : r_cell + 1'b1;
    w_nslot     = (r_cell == CELL_LAST) ? r_slot + 1'b1 : r_slot;
    w_h_next    = addr_of(BASE_H, phys_slot(r_mode, int'(r_slot)), int'(r_beat) + 1);
    w_nb_h      = addr_of(BASE_H, phys_slot(r_mode, int'(w_nslot)), 0);
    w_nb_c      = addr_of(BASE_C, phys_slot(r_mode, int'(w_nslot)), int'(w_ncell));
    w_start_h   = addr_of(BASE_H, phys_slot(bus.i_mode, 0), 0);
    w_start_c   = addr_of(BASE_C, phys_slot(bus.i_mode, 0), 0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_slot   <= '0;
      r_cell   <= '0;
      r_beat   <= '0;
      r_gap    <= '0;
      r_addr_h <= '0;
      r_addr_c <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_state  <= S_BURST;
            r_mode   <= bus.i_mode;
            r_slot   <= '0;
            r_cell   <= '0;
            r_beat   <= '0;
            r_addr_h <= w_start_h;
            r_addr_c <= w_start_c;
            r_valid  <= 1'b1;
            r_last   <= (NUM_CELL == 1);
            r_busy   <= 1'b1;
          end
        end
        S_BURST: begin
          if (bus.i_ready) begin
            if (!w_beat_last) begin
              r_beat   <= r_beat + 1'b1;
              r_addr_h <= w_h_next;
              r_last   <= (r_beat + 1'b1 == CELL_LAST);
            end else begin
              r_beat  <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              if (DELAY > 0) begin
                r_state <= S_GAP;
                r_gap   <= '0;
              end else if (w_final) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state  <= S_BURST;
                r_cell   <= w_ncell;
                r_slot   <= w_nslot;
                r_addr_h <= w_nb_h;
                r_addr_c <= w_nb_c;
                r_valid  <= 1'b1;
                r_last   <= (NUM_CELL == 1);
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (w_final) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_BURST;
              r_cell   <= w_ncell;
              r_slot   <= w_nslot;
              r_addr_h <= w_nb_h;
              r_addr_c <= w_nb_c;
              r_valid  <= 1'b1;
              r_last   <= (NUM_CELL == 1);
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_addr_h = r_addr_h;
  assign bus.o_addr_c = r_addr_c;
  assign bus.o_valid  = r_valid;
  assign bus.o_last   = r_last;
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;

endmodule

// File: tb/tb_addr_gen_hc_seq.sv
// Randomized bench for addr_gen_hc_seq: four parameterizations checked against a
// nested-loop reference of the slot/cell/beat address walk and the run-length formula.
module tb_addr_gen_hc_seq;

  localparam int NI = 4;
  localparam int P_T [NI] = '{2, 2, 2, 3};
  localparam int P_N [NI] = '{2, 2, 2, 3};
  localparam int P_D [NI] = '{1, 0, 1, 2};
  localparam int P_BH[NI] = '{'h10, 'h10, 'hFFE, 'h7F0};
  localparam int P_BC[NI] = '{'h40, 'h40, 'h40, 'h123};

  logic clk;
  logic rst;
  logic st [NI];
  logic mode;
  logic ready;
  int   sel;
  int   n_checks;
  int   n_fail;

  addr_gen_hc_seq_if #(.ADDR_WIDTH(12)) b0 ();
  addr_gen_hc_seq_if #(.ADDR_WIDTH(12)) b1 ();
  addr_gen_hc_seq_if #(.ADDR_WIDTH(12)) b2 ();
  addr_gen_hc_seq_if #(.ADDR_WIDTH(12)) b3 ();

  assign b0.i_start = st[0];
  assign b1.i_start = st[1];
  assign b2.i_start = st[2];
  assign b3.i_start = st[3];
  assign b0.i_mode = mode;
  assign b1.i_mode = mode;
  assign b2.i_mode = mode;
  assign b3.i_mode = mode;
  assign b0.i_ready = ready;
  assign b1.i_ready = ready;
  assign b2.i_ready = ready;
  assign b3.i_ready = ready;

  addr_gen_hc_seq #(.ADDR_WIDTH(12), .TIMESTEP(P_T[0]), .NUM_CELL(P_N[0]), .DELAY(P_D[0]),
                    .BASE_H(P_BH[0]), .BASE_C(P_BC[0])) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  addr_gen_hc_seq #(.ADDR_WIDTH(12), .TIMESTEP(P_T[1]), .NUM_CELL(P_N[1]), .DELAY(P_D[1]),
                    .BASE_H(P_BH[1]), .BASE_C(P_BC[1])) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  addr_gen_hc_seq #(.ADDR_WIDTH(12), .TIMESTEP(P_T[2]), .NUM_CELL(P_N[2]), .DELAY(P_D[2]),
                    .BASE_H(P_BH[2]), .BASE_C(P_BC[2])) u_dut2 (.clk(clk), .rst(rst), .bus(b2));
  addr_gen_hc_seq #(.ADDR_WIDTH(12), .TIMESTEP(P_T[3]), .NUM_CELL(P_N[3]), .DELAY(P_D[3]),
                    .BASE_H(P_BH[3]), .BASE_C(P_BC[3])) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  logic [11:0] obs_h, obs_c;
  logic        obs_valid, obs_last, obs_busy, obs_done;

  always_comb begin
    obs_h = b0.o_addr_h; obs_c = b0.o_addr_c; obs_valid = b0.o_valid;
    obs_last = b0.o_last; obs_busy = b0.o_busy; obs_done = b0.o_done;
    case (sel)
      1: begin
        obs_h = b1.o_addr_h; obs_c = b1.o_addr_c; obs_valid = b1.o_valid;
        obs_last = b1.o_last; obs_busy = b1.o_busy; obs_done = b1.o_done;
      end
      2: begin
        obs_h = b2.o_addr_h; obs_c = b2.o_addr_c; obs_valid = b2.o_valid;
        obs_last = b2.o_last; obs_busy = b2.o_busy; obs_done = b2.o_done;
      end
      3: begin
        obs_h = b3.o_addr_h; obs_c = b3.o_addr_c; obs_valid = b3.o_valid;
        obs_last = b3.o_last; obs_busy = b3.o_busy; obs_done = b3.o_done;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_h"}, 32'(obs_h), 32'h0);
    chk({tag, "_c"}, 32'(obs_c), 32'h0);
    chk({tag, "_flags"}, 32'({obs_valid, obs_last, obs_busy, obs_done}), 32'h0);
  endtask

  // Reference: expected beat stream {h, c, last} from the slot/cell/beat nesting.
  task automatic run(input int idx, input bit md, input int pct, input bit noise);
    logic [24:0] q[$];
    int          base, stalls, ph, cyc;
    logic [11:0] hold_h, hold_c;
    bit          r;
    sel = idx;
    for (int it = 0; it < P_T[idx]; it++) begin
      ph = md ? P_T[idx] - 1 - it : it;
      for (int j = 0; j < P_N[idx]; j++)
        for (int k = 0; k < P_N[idx]; k++)
          q.push_back({12'(P_BH[idx] + ph * P_N[idx] + k),
                       12'(P_BC[idx] + ph * P_N[idx] + j),
                       (k == P_N[idx] - 1)});
    end
    base   = P_T[idx] * P_N[idx] * (P_N[idx] + P_D[idx]) + 1;
    stalls = 0;
    @(negedge clk);
    hold_h = obs_h;
    hold_c = obs_c;
    st[idx] = 1'b1;
    mode    = md;
    ready   = 1'b1;
    for (cyc = 1; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (noise) begin
        st[idx] = 1'($urandom);
        mode    = 1'($urandom);
      end else begin
        st[idx] = 1'b0;
      end
      if (cyc < base + stalls) begin
        chk("busy", 32'(obs_busy), 32'h1);
        chk("done_early", 32'(obs_done), 32'h0);
        if (obs_valid) begin
          if (q.size() == 0) chk("beats_left", 32'(q.size()), 32'h1);
          else chk("beat", 32'({obs_h, obs_c, obs_last}), 32'(q[0]));
          hold_h = obs_h;
          hold_c = obs_c;
          r      = ($urandom_range(99) < pct);
          ready  = r;
          if (!r) stalls++;
          else if (q.size() > 0) void'(q.pop_front());
        end else begin
          chk("last_idle", 32'(obs_last), 32'h0);
          chk("hold_h", 32'(obs_h), 32'(hold_h));
          chk("hold_c", 32'(obs_c), 32'(hold_c));
          ready = 1'($urandom);
        end
      end else begin
        chk("done", 32'(obs_done), 32'h1);
        chk("busy_done", 32'(obs_busy), 32'h1);
        chk("valid_done", 32'(obs_valid), 32'h0);
        chk("beats_left", 32'(q.size()), 32'h0);
        @(negedge clk);
        st[idx] = 1'b0;
        chk("busy_after", 32'(obs_busy), 32'h0);
        chk("done_after", 32'(obs_done), 32'h0);
        return;
      end
    end
    chk("timeout", 32'(cyc), 32'(base + stalls));
  endtask

  task automatic reset_midrun();
    sel = 0;
    @(negedge clk);
    st[0] = 1'b1;
    mode  = 1'b0;
    ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      st[0] = 1'($urandom);
      if (c == 2) chk("running", 32'(obs_busy), 32'h1);
      if (c == 4) begin
        rst   = 1'b1;
        st[0] = 1'b1;
      end
    end
    @(negedge clk);
    chk_all_zero("rst_mid");
    rst   = 1'b0;
    st[0] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("no_done", 32'({obs_done, obs_busy, obs_valid}), 32'h0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 0;
    rst      = 1'b1;
    mode     = 1'b0;
    ready    = 1'b0;
    for (int i = 0; i < NI; i++) st[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      sel = i;
      #1;
      chk_all_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;

    run(0, 1'b0, 100, 1'b0);
    run(0, 1'b1, 100, 1'b0);
    run(0, 1'b0, 60, 1'b1);
    run(1, 1'b0, 100, 1'b0);
    run(1, 1'b1, 70, 1'b1);
    run(2, 1'b0, 100, 1'b0);
    run(2, 1'b1, 50, 1'b1);
    reset_midrun();
    run(0, 1'b0, 100, 1'b0);
    for (int n = 0; n < 6; n++)
      run(3, 1'($urandom), 30 + 10 * n, 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
